// File: rtl/axi4stream_slv_sink.sv
// AXI4-Stream slave sink: programmable tready backpressure, show-ahead receive
// FIFO and an incrementing-sequence checker with sticky error statistics.
`timescale 1ns/1ps
module axi4stream_slv_sink #(
    parameter int          DATA_WIDTH = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [1:0]            bp_mode,
    input  logic [3:0]            bp_period,
    input  logic                  chk_en,
    input  logic [DATA_WIDTH-1:0] chk_start,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [31:0]           beat_count,
    output logic [15:0]           err_count,
    output logic                  err_flag,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  allow_q;
    logic [15:0]           lfsr_q;
    logic [3:0]            duty_cnt_q;
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] expected_q;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  lfsr_fb;

    // Handshake: a beat transfers on a rising edge where tvalid and tready are
    // both high; tready depends only on registers, never on tvalid.
    assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign s_axis_tready = allow_q & ~full;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = rd_en & ~empty;
    assign rd_valid      = ~empty;
    assign rd_data       = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            allow_q    <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            duty_cnt_q <= 4'd0;
        end else begin
            lfsr_q     <= {lfsr_fb, lfsr_q[15:1]};
            duty_cnt_q <= (duty_cnt_q >= bp_period) ? 4'd0 : duty_cnt_q + 4'd1;
            case (bp_mode)
                2'b00:   allow_q <= 1'b1;
                2'b01:   allow_q <= lfsr_q[0];
                2'b10:   allow_q <= (duty_cnt_q == 4'd0);
                default: allow_q <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: rd_data is forced to zero while empty.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_count     <= 32'd0;
            err_count      <= 16'd0;
            err_flag       <= 1'b0;
            first_err_data <= '0;
            expected_q     <= '0;
        end else begin
            if (push) beat_count <= beat_count + 32'd1;
            if (!chk_en) begin
                expected_q <= chk_start;
            end else if (push) begin
                // Resync to the received value so one bad beat costs one error.
                expected_q <= s_axis_tdata + DATA_WIDTH'(1);
                if (s_axis_tdata != expected_q) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (!err_flag) first_err_data <= s_axis_tdata;
                    err_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/axi4stream_slv_sink.md
# axi4stream_slv_sink

Synthesizable AXI4-Stream slave endpoint, the receiving counterpart to the 8-bit AXI4-Stream master VIP agent used in the testbenches. It drives a configurable tready backpressure pattern: always, pseudo-random LFSR, fixed duty or stalled. Accepted beats are buffered in a show-ahead FIFO for a local reader. An in-line sequence checker compares each beat against an incrementing expected value and accumulates error statistics.

## Interface
- DATA_WIDTH, 8, tdata width in bits (≥1)
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- LFSR_SEED, 16'hACE1, reset value of the backpressure LFSR; must be non-zero
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  reset, asynchronous, active-high
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tdata  in  DATA_WIDTH  stream data
- bp_mode  in  2  00 always, 01 LFSR, 10 fixed duty, 11 stall
- bp_period  in  4  fixed-duty period; ready 1 cycle of every bp_period+1
- chk_en  in  1  checker enable
- chk_start  in  DATA_WIDTH  first expected value, loaded while chk_en=0
- rd_en  in  1  pop FIFO head
- rd_valid  out  1  FIFO not empty
- rd_data  out  DATA_WIDTH  FIFO head (show-ahead)
- beat_count  out  32  accepted beats, wraps
- err_count  out  16  mismatches, saturates at 16'hFFFF
- err_flag  out  1  sticky: at least one mismatch
- first_err_data  out  DATA_WIDTH  tdata of the first mismatching beat

## Operation
- Transfer: s_axis_tvalid & s_axis_tready at a rising edge; pushes tdata into the FIFO.
- s_axis_tready = allow_q & ~full. It is decoded from registers only, with no combinational path from tvalid.
- allow_q is a register updated each cycle from bp_mode:
  - 00: 1.
  - 01: LFSR[0]. The 16-bit Fibonacci LFSR (taps 16,14,13,11) shifts every cycle in every mode.
  - 10: 1 when duty counter = 0. The counter counts 0..bp_period and wraps, so bp_period=0 gives always ready.
  - 11: 0.
- FIFO: pop when rd_en & rd_valid; rd_en while empty is ignored.
  - Push and pop in the same cycle: occupancy unchanged.
  - When full, tready is low. A pop in a full cycle raises tready no earlier than the next cycle.
- Checker:
  - While chk_en=0: expected <= chk_start.
  - While chk_en=1, on each transfer, a mismatch (tdata ≠ expected) increments err_count with saturation and sets err_flag.
  - first_err_data captures tdata only on the mismatch that sets err_flag.
  - After every checked transfer, expected <= tdata+1 mod 2^DATA_WIDTH (resync; no error cascade).
- err_flag, err_count and first_err_data clear only on areset.
- beat_count increments on every transfer regardless of chk_en.

## Timing
- Reset values:
  - s_axis_tready=0, allow_q=0, duty counter=0, LFSR=LFSR_SEED.
  - FIFO empty: rd_valid=0, rd_data=0.
  - beat_count=0, err_count=0, err_flag=0, first_err_data=0, expected=0.
- After areset deasserts, tready can first be high in the cycle following the first rising edge. In mode 00 it is high from then on.
- A beat accepted at edge N appears on rd_data/rd_valid in cycle N+1 if the FIFO was empty. beat_count and err_count are updated at edge N.
- A bp_mode change takes effect on tready one cycle later.
- areset mid-stream: tready drops immediately (asynchronously), FIFO contents are discarded and all counters clear. The master must hold its beat.
- Wrap: FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.

## Test plan
- Mode 00, chk_start=8'h10, chk_en=1, send 16'd20 beats 8'h10..8'h23 with continuous rd_en -> beat_count=20, err_count=0, err_flag=0, rd_data sequence 8'h10..8'h23.
- FIFO_DEPTH=8, mode 00, rd_en=0, tvalid held -> exactly 8 beats accepted, tready=0 from the cycle after the 8th. Pulse rd_en once -> one more beat accepted, count=9.
- Mode 01, 1000 beats, continuous read -> all data in order and tready toggles. Reference model: with LFSR_SEED=16'hACE1, the tready sequence matches LFSR[0] delayed one cycle.
- Mode 10, bp_period=3, tvalid held -> tready high 1 of every 4 cycles; 8 beats take 32 cycles.
- Checker, chk_start=0: send 0,1,2,7,8,9 -> err_count=1, first_err_data=8'h07, err_flag=1; 8 and 9 are not counted as errors.
- areset asserted mid-burst with a full FIFO -> tready=0 immediately, rd_valid=0 and all counters 0 after release. Stream resumes cleanly.
